// File: rtl/ptw_arb_pkg.sv
// ptw_arb_pkg: shared types for the PTW/load-unit dcache read-port arbiter.
package ptw_arb_pkg;
    localparam int ARB_IDX_W = 12;
    localparam int ARB_TAG_W = 44;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_ID_W = 2;

    typedef enum logic {IDLE, LOCK} arb_state_e;

    typedef struct packed {
        logic [ARB_IDX_W-1:0] index;
        logic [7:0]           be;
        logic [1:0]           size;
        logic [ARB_ID_W-1:0]  id;
    } dcache_rd_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [ARB_ID_W-1:0]   rid;
        logic [ARB_DATA_W-1:0] rdata;
    } dcache_rd_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[ptr + W'(k)]) begin
                valid = 1'b1;
                idx = ptr + W'(k);
            end
        end
        onehot = valid ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/ptw_dcache_port_arbiter.sv
// ptw_dcache_port_arbiter: shares one dcache read port among NUM_REQ requesters,
// tagging downstream ids with the requester index and routing responses back.
module ptw_dcache_port_arbiter
    import ptw_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = ARB_IDX_W,
    parameter int TAG_W   = ARB_TAG_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int ID_W    = ARB_ID_W,
    parameter int MAX_OUT = 2,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_data_req_i,
    output logic [NUM_REQ-1:0]        req_data_gnt_o,
    input  logic [NUM_REQ*IDX_W-1:0]  req_addr_index_i,
    input  logic [NUM_REQ*8-1:0]      req_data_be_i,
    input  logic [NUM_REQ*2-1:0]      req_data_size_i,
    input  logic [NUM_REQ*ID_W-1:0]   req_data_id_i,
    input  logic [NUM_REQ*TAG_W-1:0]  req_addr_tag_i,
    output logic [NUM_REQ-1:0]        req_data_rvalid_o,
    output logic [ID_W-1:0]           req_data_rid_o,
    output logic [DATA_W-1:0]         req_data_rdata_o,
    output logic                      mem_data_req_o,
    input  logic                      mem_data_gnt_i,
    output logic [IDX_W-1:0]          mem_address_index_o,
    output logic [7:0]                mem_data_be_o,
    output logic [1:0]                mem_data_size_o,
    output logic [ID_W+SEL_W-1:0]     mem_data_id_o,
    output logic [TAG_W-1:0]          mem_address_tag_o,
    output logic                      mem_tag_valid_o,
    output logic                      mem_kill_req_o,
    input  logic                      mem_data_rvalid_i,
    input  logic [ID_W+SEL_W-1:0]     mem_data_rid_i,
    input  logic [DATA_W-1:0]         mem_data_rdata_i,
    output logic                      busy_o,
    output logic                      err_unexp_rsp_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int RID_W = ID_W + SEL_W;
    localparam int NID = 1 << RID_W;

    arb_state_e state;
    logic [SEL_W-1:0] rr_ptr, owner, tag_owner, win_idx, sel, rs;
    logic [ID_W-1:0] tag_id, sel_id;
    logic [NUM_REQ-1:0] elig, win_oh;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
    logic [NID-1:0] drop;
    logic tag_pend, any_elig, active, grant, rsp_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_data_req_i[i] && cnt[i] < CNT_W'(MAX_OUT) && !flush_i;
    end

    rr_arbiter #(.N(NUM_REQ), .W(SEL_W)) u_arb (
        .req(elig), .ptr(rr_ptr), .onehot(win_oh), .idx(win_idx), .valid(any_elig)
    );

    // A locked owner keeps the port even if its count would now block it; it cannot grow while locked.
    assign sel = (state == LOCK) ? owner : win_idx;
    assign active = (state == LOCK) ? req_data_req_i[owner] && !flush_i : any_elig;
    assign grant = active && mem_data_gnt_i;
    assign sel_id = req_data_id_i[sel*ID_W +: ID_W];

    assign req_data_gnt_o = !grant ? '0 : (state == LOCK) ? NUM_REQ'(1) << owner : win_oh;
    assign mem_data_req_o = active;
    assign mem_address_index_o = active ? req_addr_index_i[sel*IDX_W +: IDX_W] : '0;
    assign mem_data_be_o = active ? req_data_be_i[sel*8 +: 8] : '0;
    assign mem_data_size_o = active ? req_data_size_i[sel*2 +: 2] : '0;
    assign mem_data_id_o = active ? {sel, sel_id} : '0;

    assign mem_tag_valid_o = tag_pend;
    assign mem_address_tag_o = tag_pend ? req_addr_tag_i[tag_owner*TAG_W +: TAG_W] : '0;
    assign mem_kill_req_o = tag_pend && flush_i;

    assign rs = mem_data_rid_i[RID_W-1:ID_W];
    assign rsp_ok = mem_data_rvalid_i && cnt[rs] != '0;
    assign req_data_rvalid_o = (rsp_ok && !drop[mem_data_rid_i]) ? NUM_REQ'(1) << rs : '0;
    assign req_data_rid_o = rsp_ok ? mem_data_rid_i[ID_W-1:0] : '0;
    assign req_data_rdata_o = rsp_ok ? mem_data_rdata_i : '0;

    assign busy_o = (state != IDLE) || tag_pend || (|cnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            tag_owner <= '0;
            tag_id <= '0;
            tag_pend <= 1'b0;
            cnt <= '0;
            drop <= '0;
            err_unexp_rsp_o <= 1'b0;
        end else begin
            state <= (active && !mem_data_gnt_i) ? LOCK : IDLE;
            if (active)
                owner <= sel;
            tag_pend <= grant;
            if (grant) begin
                tag_owner <= sel;
                tag_id <= sel_id;
                rr_ptr <= sel + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= cnt[i] + CNT_W'(grant && sel == SEL_W'(i)) - CNT_W'(rsp_ok && rs == SEL_W'(i));
            if (rsp_ok)
                drop[mem_data_rid_i] <= 1'b0;
            if (tag_pend && flush_i)
                drop[{tag_owner, tag_id}] <= 1'b1;
            if (mem_data_rvalid_i && cnt[rs] == '0)
                err_unexp_rsp_o <= 1'b1;
        end
    end
endmodule
